// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - sequential instruction-memory reader with 2-entry output buffer
module instr_fetch #(
  parameter int DATA_WIDTH = 60,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   end_q;
  logic                    inflight;
  logic [1:0]              count;
  logic [DATA_WIDTH-1:0]   buf0, buf1;
  logic                    busy_q, done_q;

  logic                    pop;
  logic                    issue;
  logic                    can_issue;
  logic                    flush;
  logic                    drain_fire;
  logic [1:0]              tail;

  assign pop         = (count != 2'd0) && instr_ready;
  assign flush       = abort && (state != IDLE);
  // A slot is reserved for every in-flight read, so issue only while a free slot remains.
  assign can_issue   = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign tail        = count - {1'b0, pop};

  assign mem_addr    = pc;
  assign instr_out   = buf0;
  assign instr_valid = (count != 2'd0);
  assign busy        = busy_q;
  assign done        = done_q;

  // Next-state, issue and drain-completion decode.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    drain_fire = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        if (abort) begin
          state_next = IDLE;
        end else if (can_issue) begin
          issue = 1'b1;
          if (pc == end_q) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (done_q) begin
          // done is shown for one cycle while still busy; leave afterwards.
          state_next = IDLE;
        end else if (!inflight && (count == 2'd0 || (count == 2'd1 && pop))) begin
          drain_fire = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers: state, address counter, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      end_q    <= '0;
      inflight <= 1'b0;
      count    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
      done_q <= drain_fire;
      if (state == IDLE && start) begin
        pc    <= start_addr;
        end_q <= end_addr;
      end else if (issue && pc != end_q) begin
        pc <= pc + ADDR_WIDTH'(1);
      end
      if (flush) begin
        inflight <= 1'b0;
        count    <= 2'd0;
      end else begin
        inflight <= issue;
        count    <= count + {1'b0, inflight} - {1'b0, pop};
      end
    end
  end

  // Buffer storage: shift on pop, then land the returning word at the new tail.
  always_ff @(posedge clk) begin
    if (pop) buf0 <= buf1;
    if (inflight) begin
      if (tail == 2'd0) buf0 <= mem_data;
      else              buf1 <= mem_data;
    end
  end

endmodule
